// File: rtl/food_controller.sv
// Food map for a 16x16 tile maze: loads pellet codes from ROM, serves the
// per-pixel food code to the renderer, and handles eat requests and scoring.
module food_controller #(
    parameter int TILES      = 256,
    parameter int PELLET_PTS = 10,
    parameter int POWER_PTS  = 50
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    input  logic       level_start,
    output logic [7:0] rom_addr,
    input  logic [1:0] rom_q,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    output logic [1:0] pix_food,
    input  logic       eat_req,
    input  logic [7:0] eat_tile,
    output logic       eat_ack,
    output logic [1:0] eat_kind,
    output logic [8:0] remaining,
    output logic [15:0] score,
    output logic       level_clear,
    output logic       busy
);

    typedef enum logic [1:0] {LOAD, RUN, ACK, DONE} state_t;

    localparam logic [8:0] K_LAST = 9'(TILES);

    state_t     state, state_nxt;
    logic [8:0] k;
    logic [1:0] map [TILES];

    logic [7:0] load_idx;
    logic       load_inc;
    logic [8:0] rem_after_load;
    logic [1:0] cur_code;
    logic [1:0] food_kind;
    logic       eat_go;
    logic [16:0] score_sum;
    logic [3:0] tx, ty;
    logic [7:0] pix_idx;
    logic       pix_off;

    // rom_q lags rom_addr by one cycle, so the word arriving now belongs to k-1
    assign load_idx       = k[7:0] - 8'd1;
    assign load_inc       = (k != 9'd0) && (rom_q == 2'd1 || rom_q == 2'd2);
    assign rem_after_load = remaining + {8'd0, load_inc};

    assign cur_code  = map[eat_tile];
    assign food_kind = (cur_code == 2'd1 || cur_code == 2'd2) ? cur_code : 2'd0;
    assign eat_go    = (state == RUN) && eat_req && !level_start;
    assign score_sum = {1'b0, score} +
                       ((food_kind == 2'd2) ? 17'(POWER_PTS) : 17'(PELLET_PTS));

    assign tx      = 4'(DrawX / 10'd40);
    assign ty      = 4'(DrawY / 10'd30);
    assign pix_idx = {ty, tx};
    assign pix_off = (DrawX >= 10'd640) || (DrawY >= 10'd480) || (state == LOAD);

    assign rom_addr    = (state == LOAD) ? k[7:0] : 8'd0;
    assign busy        = (state == LOAD);
    assign level_clear = (state == DONE);

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) state <= LOAD;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD: if (k == K_LAST) state_nxt = (rem_after_load == 9'd0) ? DONE : RUN;
            RUN:  if (eat_req) state_nxt = ACK;
            ACK:  state_nxt = (remaining == 9'd0) ? DONE : RUN;
            DONE: state_nxt = DONE;
            default: state_nxt = LOAD;
        endcase
        if (level_start) state_nxt = LOAD;
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            k         <= 9'd0;
            eat_ack   <= 1'b0;
            eat_kind  <= 2'd0;
            remaining <= 9'd0;
            score     <= 16'd0;
        end else if (level_start) begin
            k         <= 9'd0;
            eat_ack   <= 1'b0;
            remaining <= 9'd0;
        end else begin
            eat_ack <= 1'b0;
            case (state)
                LOAD: begin
                    k         <= (k == K_LAST) ? 9'd0 : k + 9'd1;
                    remaining <= rem_after_load;
                end
                RUN: if (eat_req) begin
                    eat_ack  <= 1'b1;
                    eat_kind <= food_kind;
                    if (food_kind != 2'd0) begin
                        remaining <= remaining - 9'd1;
                        score     <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
                    end
                end
                default: ;
            endcase
        end
    end

    // Map contents survive reset; the forced reload rewrites every entry
    always_ff @(posedge vga_clk) begin
        if (!level_start) begin
            if (state == LOAD && k != 9'd0)
                map[load_idx] <= rom_q;
            else if (eat_go && food_kind != 2'd0)
                map[eat_tile] <= 2'd0;
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n)     pix_food <= 2'd0;
        else if (pix_off) pix_food <= 2'd0;
        else              pix_food <= map[pix_idx];
    end

endmodule

// File: tb/tb_food_controller.sv
// Scoreboard bench for food_controller: ROM model, shadow food map, score model.
module tb_food_controller;

    logic        vga_clk = 1'b0;
    logic        reset_n;
    logic        level_start;
    logic [7:0]  rom_addr;
    logic [1:0]  rom_q;
    logic [9:0]  DrawX, DrawY;
    logic [1:0]  pix_food;
    logic        eat_req;
    logic [7:0]  eat_tile;
    logic        eat_ack;
    logic [1:0]  eat_kind;
    logic [8:0]  remaining;
    logic [15:0] score;
    logic        level_clear;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [1:0]  rom  [256];
    logic [1:0]  mmap [256];
    int          m_rem;
    int          m_score;
    logic [1:0]  exp_q [$];

    food_controller dut (
        .vga_clk(vga_clk), .reset_n(reset_n), .level_start(level_start),
        .rom_addr(rom_addr), .rom_q(rom_q), .DrawX(DrawX), .DrawY(DrawY),
        .pix_food(pix_food), .eat_req(eat_req), .eat_tile(eat_tile),
        .eat_ack(eat_ack), .eat_kind(eat_kind), .remaining(remaining),
        .score(score), .level_clear(level_clear), .busy(busy)
    );

    always #5 vga_clk = ~vga_clk;

    always @(posedge vga_clk) rom_q <= rom[rom_addr];

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    // mode 0: level_start pulse (with whatever eat_req is driven), mode 1: reset release
    task automatic load_level(input int mode);
        int n;
        if (mode == 1) begin
            reset_n = 1'b1;
            n = 0;
        end else begin
            level_start = 1'b1;
            tick();
            level_start = 1'b0;
            eat_req = 1'b0;
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_busy got %0b want 1", busy); end
            checks++; if (level_clear !== 1'b0) begin errors++; $display("FAIL start_clear got %0b want 0", level_clear); end
            checks++; if (eat_ack !== 1'b0) begin errors++; $display("FAIL start_ack got %0b want 0", eat_ack); end
            checks++; if (score !== 16'(m_score)) begin errors++; $display("FAIL start_score got %0d want %0d", score, m_score); end
            n = 0;
        end
        do begin
            tick();
            n++;
            if (n == 100) begin
                checks++; if (rom_addr !== 8'd100) begin errors++; $display("FAIL load_addr got %0d want 100", rom_addr); end
            end
            if (n == 50) begin
                checks++; if (pix_food !== 2'd0) begin errors++; $display("FAIL load_pix got %0d want 0", pix_food); end
            end
        end while (busy && n < 400);
        checks++; if (n != 257) begin errors++; $display("FAIL load_cycles got %0d want 257", n); end
        m_rem = 0;
        for (int i = 0; i < 256; i++) begin
            mmap[i] = rom[i];
            if (rom[i] == 2'd1 || rom[i] == 2'd2) m_rem++;
        end
        checks++; if (remaining !== 9'(m_rem)) begin errors++; $display("FAIL load_remaining got %0d want %0d", remaining, m_rem); end
        checks++; if (level_clear !== (m_rem == 0)) begin errors++; $display("FAIL load_clear got %0b want %0b", level_clear, m_rem == 0); end
        checks++; if (rom_addr !== 8'd0) begin errors++; $display("FAIL idle_addr got %0d want 0", rom_addr); end
        checks++; if (score !== 16'(m_score)) begin errors++; $display("FAIL load_score got %0d want %0d", score, m_score); end
    endtask

    task automatic do_eat(input int t);
        logic [1:0] k, got;
        k = (mmap[t] == 2'd1 || mmap[t] == 2'd2) ? mmap[t] : 2'd0;
        exp_q.push_back(k);
        if (k != 2'd0) begin
            mmap[t] = 2'd0;
            m_rem--;
            m_score = m_score + ((k == 2'd2) ? 50 : 10);
            if (m_score > 65535) m_score = 65535;
        end
        eat_tile = 8'(t);
        eat_req = 1'b1;
        tick();
        eat_req = 1'b0;
        got = exp_q.pop_front();
        checks++;
        if (eat_ack !== 1'b1) begin errors++; $display("FAIL eat_ack tile %0d got %0b want 1", t, eat_ack); end
        else if (eat_kind !== got) begin errors++; $display("FAIL eat_kind tile %0d got %0d want %0d", t, eat_kind, got); end
        checks++; if (score !== 16'(m_score)) begin errors++; $display("FAIL eat_score tile %0d got %0d want %0d", t, score, m_score); end
        checks++; if (remaining !== 9'(m_rem)) begin errors++; $display("FAIL eat_remaining tile %0d got %0d want %0d", t, remaining, m_rem); end
        tick();
        checks++; if (eat_ack !== 1'b0) begin errors++; $display("FAIL ack_width tile %0d got %0b want 0", t, eat_ack); end
        checks++; if (eat_kind !== got) begin errors++; $display("FAIL kind_hold tile %0d got %0d want %0d", t, eat_kind, got); end
        checks++; if (level_clear !== (m_rem == 0)) begin errors++; $display("FAIL eat_clear got %0b want %0b", level_clear, m_rem == 0); end
    endtask

    task automatic test_reset();
        tick(); tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy got %0b want 1", busy); end
        checks++; if (rom_addr !== 8'd0) begin errors++; $display("FAIL rst_addr got %0d want 0", rom_addr); end
        checks++; if ({pix_food, eat_ack, eat_kind} !== 5'd0) begin errors++; $display("FAIL rst_outs got %b want 0", {pix_food, eat_ack, eat_kind}); end
        checks++; if (remaining !== 9'd0 || score !== 16'd0) begin errors++; $display("FAIL rst_counts got %0d/%0d want 0/0", remaining, score); end
        checks++; if (level_clear !== 1'b0) begin errors++; $display("FAIL rst_clear got %0b want 0", level_clear); end
    endtask

    task automatic test_load();
        for (int i = 0; i < 256; i++) rom[i] = 2'(i % 4);
        load_level(1);
    endtask

    task automatic test_eat();
        do_eat(1);
        do_eat(1);
        do_eat(2);
        do_eat(3);
    endtask

    task automatic test_back_to_back();
        // request held through the ACK cycle: only two acks in three cycles
        eat_tile = 8'd5; eat_req = 1'b1;
        exp_q.push_back(2'd1);
        tick();
        eat_tile = 8'd9;
        checks++; if (eat_ack !== 1'b1 || eat_kind !== exp_q.pop_front()) begin errors++; $display("FAIL b2b_first got %0b/%0d want 1/1", eat_ack, eat_kind); end
        tick();
        checks++; if (eat_ack !== 1'b0) begin errors++; $display("FAIL b2b_gap got %0b want 0", eat_ack); end
        exp_q.push_back(2'd1);
        tick();
        eat_req = 1'b0;
        checks++; if (eat_ack !== 1'b1 || eat_kind !== exp_q.pop_front()) begin errors++; $display("FAIL b2b_second got %0b/%0d want 1/1", eat_ack, eat_kind); end
        mmap[5] = 2'd0; mmap[9] = 2'd0; m_rem -= 2; m_score += 20;
        tick();
        checks++; if (remaining !== 9'(m_rem) || score !== 16'(m_score)) begin errors++; $display("FAIL b2b_counts got %0d/%0d want %0d/%0d", remaining, score, m_rem, m_score); end
    endtask

    task automatic test_pixel();
        DrawX = 10'd45; DrawY = 10'd35;
        tick();
        checks++; if (pix_food !== mmap[17]) begin errors++; $display("FAIL pix_17 got %0d want %0d", pix_food, mmap[17]); end
        do_eat(17);
        checks++; if (pix_food !== 2'd0) begin errors++; $display("FAIL pix_17_eaten got %0d want 0", pix_food); end
        DrawX = 10'd639; DrawY = 10'd479;
        tick();
        checks++; if (pix_food !== mmap[255]) begin errors++; $display("FAIL pix_255 got %0d want %0d", pix_food, mmap[255]); end
        DrawX = 10'd640;
        tick();
        checks++; if (pix_food !== 2'd0) begin errors++; $display("FAIL pix_x640 got %0d want 0", pix_food); end
        DrawX = 10'd0; DrawY = 10'd480;
        tick();
        checks++; if (pix_food !== 2'd0) begin errors++; $display("FAIL pix_y480 got %0d want 0", pix_food); end
        // pixel read on the same edge as the eat sees the old code
        DrawX = 10'd85; DrawY = 10'd35;
        eat_tile = 8'd18; eat_req = 1'b1;
        exp_q.push_back(mmap[18]);
        tick();
        eat_req = 1'b0;
        checks++; if (pix_food !== 2'd2) begin errors++; $display("FAIL pix_pre_update got %0d want 2", pix_food); end
        checks++; if (eat_ack !== 1'b1 || eat_kind !== exp_q.pop_front()) begin errors++; $display("FAIL eat_18 got %0b/%0d want 1/2", eat_ack, eat_kind); end
        mmap[18] = 2'd0; m_rem--; m_score += 50;
        tick();
        checks++; if (pix_food !== 2'd0) begin errors++; $display("FAIL pix_post_update got %0d want 0", pix_food); end
        checks++; if (score !== 16'(m_score)) begin errors++; $display("FAIL eat_18_score got %0d want %0d", score, m_score); end
    endtask

    task automatic test_collision();
        eat_tile = 8'd21; eat_req = 1'b1;
        load_level(0);
    endtask

    task automatic test_done();
        for (int i = 0; i < 256; i++) rom[i] = 2'd0;
        rom[5] = 2'd1; rom[0] = 2'd3;
        load_level(0);
        do_eat(5);
        DrawX = 10'd0; DrawY = 10'd0;
        eat_tile = 8'd5; eat_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (eat_ack !== 1'b0) begin errors++; $display("FAIL done_ack got %0b want 0", eat_ack); end
        end
        eat_req = 1'b0;
        checks++; if (pix_food !== 2'd3) begin errors++; $display("FAIL done_pix got %0d want 3", pix_food); end
        checks++; if (level_clear !== 1'b1) begin errors++; $display("FAIL done_clear got %0b want 1", level_clear); end
        rom[5] = 2'd0; rom[0] = 2'd0;
        load_level(0);
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 256; i++) rom[i] = 2'd2;
        while (m_score != 65535) begin
            load_level(0);
            for (int t = 0; t < 256; t++)
                if (m_score != 65535) do_eat(t);
        end
        load_level(0);
        do_eat(0);
        do_eat(1);
    endtask

    task automatic test_reset_midload();
        for (int i = 0; i < 256; i++) rom[i] = 2'(i % 4);
        level_start = 1'b1;
        tick();
        level_start = 1'b0;
        repeat (100) tick();
        checks++; if (rom_addr !== 8'd100) begin errors++; $display("FAIL mid_addr got %0d want 100", rom_addr); end
        reset_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b1 || rom_addr !== 8'd0) begin errors++; $display("FAIL mid_rst_busy_addr got %0b/%0d want 1/0", busy, rom_addr); end
        checks++; if ({pix_food, eat_ack, eat_kind, level_clear} !== 6'd0) begin errors++; $display("FAIL mid_rst_outs got %b want 0", {pix_food, eat_ack, eat_kind, level_clear}); end
        checks++; if (remaining !== 9'd0 || score !== 16'd0) begin errors++; $display("FAIL mid_rst_counts got %0d/%0d want 0/0", remaining, score); end
        m_score = 0;
        tick();
        load_level(1);
        do_eat(2);
    endtask

    initial begin
        reset_n = 1'b0; level_start = 1'b0; eat_req = 1'b0; eat_tile = 8'd0;
        DrawX = 10'd45; DrawY = 10'd35;
        m_rem = 0; m_score = 0;
        for (int i = 0; i < 256; i++) begin rom[i] = 2'd0; mmap[i] = 2'd0; end
        test_reset();
        test_load();
        test_eat();
        test_back_to_back();
        test_pixel();
        test_collision();
        test_done();
        test_saturate();
        test_reset_midload();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
